// File: rtl/life_pkg.sv
// Shared types and constants for the player lives/respawn sequencer.
package life_pkg;

  typedef enum logic [2:0] {
    ALIVE,
    DYING,
    RESPAWN,
    INVULN,
    GAMEOVER
  } life_state_t;

  localparam int unsigned LIVES_W   = 2;
  localparam int unsigned MAX_ICONS = 3;

  // Icon enables: bit i lit while more than i lives remain.
  function automatic logic [MAX_ICONS-1:0] icons_for(input logic [LIVES_W-1:0] n);
    logic [MAX_ICONS-1:0] v;
    for (int unsigned i = 0; i < MAX_ICONS; i++) begin
      v[i] = (32'(n) > 32'(i));
    end
    return v;
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings an asynchronous frame-rate clock into the Clk domain and emits a
// one-cycle tick on each synchronised rising edge; the tick is consumed on
// the third Clk edge after async_in rises.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic async_in,
  output logic tick
);

  logic sync_q1;
  logic sync_q2;
  logic hist_q;

  // Two-flop synchroniser followed by a history flop for edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync_q1 <= async_in;
      sync_q2 <= sync_q1;
      hist_q  <= sync_q2;
    end
  end

  assign tick = sync_q2 & ~hist_q;

endmodule

// File: rtl/life_ctrl.sv
// Lives/respawn sequencer for the player sprite and life-icon renderer.
// Optional feature: define LIFE_CTRL_EXTRA_LIFE_EN to add the extra_life input.
module life_ctrl
  import life_pkg::*;
#(
  parameter int unsigned NUM_LIVES      = 3,
  parameter int unsigned RESPAWN_FRAMES = 60,
  parameter int unsigned INVULN_FRAMES  = 120,
  parameter int unsigned BLINK_PERIOD   = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic                 hit,
  input  logic                 restart,
`ifdef LIFE_CTRL_EXTRA_LIFE_EN
  input  logic                 extra_life,
`endif
  output logic [LIVES_W-1:0]   lives,
  output logic [MAX_ICONS-1:0] life_vis,
  output logic                 game_over,
  output logic                 player_freeze,
  output logic                 player_visible,
  output logic                 respawn
);

  localparam int unsigned MAX_FRAMES = (RESPAWN_FRAMES > INVULN_FRAMES) ? RESPAWN_FRAMES : INVULN_FRAMES;
  localparam int unsigned BLINK_BIT  = $clog2(BLINK_PERIOD);
  localparam int unsigned FCNT_MIN_W = $clog2(MAX_FRAMES + 1);
  // Counter must also be wide enough to hold the blink bit.
  localparam int unsigned FCNT_W     = (FCNT_MIN_W > BLINK_BIT) ? FCNT_MIN_W : BLINK_BIT + 1;

  localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(NUM_LIVES);
  localparam logic [FCNT_W-1:0]  RESPAWN_LAST = FCNT_W'(RESPAWN_FRAMES - 1);
  localparam logic [FCNT_W-1:0]  INVULN_LAST  = FCNT_W'(INVULN_FRAMES - 1);

  life_state_t          state_q, state_d;
  logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
  logic [LIVES_W-1:0]   lives_d;
  logic [MAX_ICONS-1:0] life_vis_d;
  logic                 game_over_d;
  logic                 player_freeze_d;
  logic                 player_visible_d;
  logic                 respawn_d;
  logic                 ftick;

  frame_tick_sync u_tick (
    .Clk      (Clk),
    .Reset    (Reset),
    .async_in (frame_clk),
    .tick     (ftick)
  );

`ifdef LIFE_CTRL_EXTRA_LIFE_EN
  logic [LIVES_W-1:0] lives_inc;
  assign lives_inc = (lives < LIVES_INIT) ? lives + LIVES_W'(1) : lives;
`endif

  // Next-state, frame counter, lives and decoded next outputs.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    lives_d = lives;

    if (restart) begin
      lives_d = LIVES_INIT;
      fcnt_d  = '0;
      state_d = RESPAWN;
    end else begin
      case (state_q)
        ALIVE: begin
          if (hit) begin
`ifdef LIFE_CTRL_EXTRA_LIFE_EN
            if (!extra_life) lives_d = lives - LIVES_W'(1);
`else
            lives_d = lives - LIVES_W'(1);
`endif
            fcnt_d  = '0;
            state_d = DYING;
          end
`ifdef LIFE_CTRL_EXTRA_LIFE_EN
          else if (extra_life) begin
            lives_d = lives_inc;
          end
`endif
        end
        DYING: begin
          if (ftick) begin
            if (fcnt_q == RESPAWN_LAST) begin
              state_d = (lives == '0) ? GAMEOVER : RESPAWN;
            end else begin
              fcnt_d = fcnt_q + FCNT_W'(1);
            end
          end
        end
        RESPAWN: begin
          fcnt_d  = '0;
          state_d = INVULN;
        end
        INVULN: begin
`ifdef LIFE_CTRL_EXTRA_LIFE_EN
          if (extra_life) lives_d = lives_inc;
`endif
          if (ftick) begin
            if (fcnt_q == INVULN_LAST) begin
              state_d = ALIVE;
            end else begin
              fcnt_d = fcnt_q + FCNT_W'(1);
            end
          end
        end
        GAMEOVER: begin
          state_d = GAMEOVER;
        end
        default: begin
          state_d = ALIVE;
        end
      endcase
    end

    life_vis_d      = icons_for(lives_d);
    game_over_d     = (state_d == GAMEOVER);
    player_freeze_d = (state_d == DYING) || (state_d == GAMEOVER);
    respawn_d       = (state_d == RESPAWN);
    case (state_d)
      INVULN:   player_visible_d = ~fcnt_d[BLINK_BIT];
      GAMEOVER: player_visible_d = 1'b0;
      default:  player_visible_d = 1'b1;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= ALIVE;
      fcnt_q         <= '0;
      lives          <= LIVES_INIT;
      life_vis       <= icons_for(LIVES_INIT);
      game_over      <= 1'b0;
      player_freeze  <= 1'b0;
      player_visible <= 1'b1;
      respawn        <= 1'b0;
    end else begin
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      lives          <= lives_d;
      life_vis       <= life_vis_d;
      game_over      <= game_over_d;
      player_freeze  <= player_freeze_d;
      player_visible <= player_visible_d;
      respawn        <= respawn_d;
    end
  end

endmodule

// File: tb/tb_life_ctrl.sv
// Scoreboard bench for life_ctrl: stimulus queues every expected output
// change; the monitor pops and compares each time the output vector changes.
module tb_life_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic       hit = 1'b0;
  logic       restart = 1'b0;
`ifdef LIFE_CTRL_EXTRA_LIFE_EN
  logic       extra_life = 1'b0;
`endif
  logic [1:0] lives;
  logic [2:0] life_vis;
  logic       game_over;
  logic       player_freeze;
  logic       player_visible;
  logic       respawn;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];
  string      name_q[$];
  logic [8:0] last_snap = 'x;

  life_ctrl #(
    .NUM_LIVES      (3),
    .RESPAWN_FRAMES (4),
    .INVULN_FRAMES  (8),
    .BLINK_PERIOD   (2)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .frame_clk      (frame_clk),
    .hit            (hit),
    .restart        (restart),
`ifdef LIFE_CTRL_EXTRA_LIFE_EN
    .extra_life     (extra_life),
`endif
    .lives          (lives),
    .life_vis       (life_vis),
    .game_over      (game_over),
    .player_freeze  (player_freeze),
    .player_visible (player_visible),
    .respawn        (respawn)
  );

  always #5 Clk = ~Clk;

  function automatic logic [8:0] mk(input logic [1:0] l, input logic [2:0] v,
                                    input logic go, input logic frz,
                                    input logic pv, input logic rsp);
    return {l, v, go, frz, pv, rsp};
  endfunction

  task automatic expect_out(input string nm, input logic [8:0] s);
    exp_q.push_back(s);
    name_q.push_back(nm);
  endtask

  // Monitor: every change of the output vector must match the next expectation.
  initial begin
    logic [8:0] snap;
    logic [8:0] e;
    string      nm;
    forever begin
      @(negedge Clk);
      snap = {lives, life_vis, game_over, player_freeze, player_visible, respawn};
      if (snap !== last_snap) begin
        last_snap = snap;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change at %0t: got lives/vis/go/frz/pv/rsp=%b, required no change", $time, snap);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (snap !== e) begin
            n_fail++;
            $display("FAIL %s at %0t: got lives/vis/go/frz/pv/rsp=%b, required %b", nm, $time, snap, e);
          end
        end
      end
    end
  end

  task automatic wait_drain(input string nm);
    int budget = 50;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge Clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: %0d expected changes never seen (next %s), required 0 pending", nm, exp_q.size(), name_q[0]);
      exp_q.delete();
      name_q.delete();
    end
  endtask

  // One frame: high 3 Clk, low 3 Clk; the tick lands within the high phase.
  task automatic frame_pulse();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic pulse_hit();
    @(negedge Clk) hit = 1'b1;
    @(negedge Clk) hit = 1'b0;
  endtask

  task automatic dying_to_respawn(input logic [1:0] l, input logic [2:0] v);
    repeat (3) frame_pulse();
    expect_out("respawn_pulse", mk(l, v, 1'b0, 1'b0, 1'b1, 1'b1));
    expect_out("enter_invuln",  mk(l, v, 1'b0, 1'b0, 1'b1, 1'b0));
    frame_pulse();
    wait_drain("respawn_seq");
  endtask

  // Blink with BLINK_PERIOD=2: visible for fcnt 0,1 and 4,5; ALIVE on tick 8.
  task automatic invuln_phase(input logic [1:0] l, input logic [2:0] v, input logic hit_mid);
    for (int k = 1; k <= 8; k++) begin
      if (k == 2 || k == 6) expect_out("blink_off", mk(l, v, 1'b0, 1'b0, 1'b0, 1'b0));
      if (k == 4)           expect_out("blink_on",  mk(l, v, 1'b0, 1'b0, 1'b1, 1'b0));
      if (k == 8)           expect_out("back_alive", mk(l, v, 1'b0, 1'b0, 1'b1, 1'b0));
      if (hit_mid && k == 3) hit = 1'b1;
      frame_pulse();
      hit = 1'b0;
    end
    wait_drain("invuln_seq");
  endtask

  task automatic chk_tick(input string nm, input logic req);
    n_checks++;
    if (dut.u_tick.tick !== req) begin
      n_fail++;
      $display("FAIL %s: got tick=%b, required %b", nm, dut.u_tick.tick, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    expect_out("reset_state", mk(2'd3, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0));
    #1 Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    wait_drain("reset");

    // Frame tick latency and width.
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) chk_tick("tick_after_edge1", 1'b0);
    @(negedge Clk) chk_tick("tick_after_edge2", 1'b1);
    @(negedge Clk) chk_tick("tick_after_edge3", 1'b0);
    @(negedge Clk) chk_tick("tick_held_high", 1'b0);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);

    // First hit and respawn, hit ignored during INVULN.
    expect_out("hit1_dying", mk(2'd2, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0));
    pulse_hit();
    dying_to_respawn(2'd2, 3'b011);
    invuln_phase(2'd2, 3'b011, 1'b1);

    // Second life.
    expect_out("hit2_dying", mk(2'd1, 3'b001, 1'b0, 1'b1, 1'b1, 1'b0));
    pulse_hit();
    dying_to_respawn(2'd1, 3'b001);
    invuln_phase(2'd1, 3'b001, 1'b0);

    // Last life: game over without a respawn pulse.
    expect_out("hit3_dying", mk(2'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0));
    pulse_hit();
    repeat (3) frame_pulse();
    expect_out("game_over", mk(2'd0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0));
    frame_pulse();
    wait_drain("game_over_seq");
    repeat (2) frame_pulse();
    pulse_hit();
    repeat (4) @(negedge Clk);

    // Restart from GAMEOVER.
    expect_out("restart_go_respawn", mk(2'd3, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1));
    expect_out("restart_go_invuln",  mk(2'd3, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge Clk) restart = 1'b1;
    @(negedge Clk) restart = 1'b0;
    wait_drain("restart_go");
    invuln_phase(2'd3, 3'b111, 1'b0);

    // Restart during DYING with hit high in the same cycle.
    expect_out("hit4_dying", mk(2'd2, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0));
    pulse_hit();
    frame_pulse();
    expect_out("restart_dy_respawn", mk(2'd3, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1));
    expect_out("restart_dy_invuln",  mk(2'd3, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge Clk) begin restart = 1'b1; hit = 1'b1; end
    @(negedge Clk) begin restart = 1'b0; hit = 1'b0; end
    wait_drain("restart_dy");
    invuln_phase(2'd3, 3'b111, 1'b0);

`ifdef LIFE_CTRL_EXTRA_LIFE_EN
    // Extra life at the cap has no effect.
    @(negedge Clk) extra_life = 1'b1;
    @(negedge Clk) extra_life = 1'b0;
    repeat (3) @(negedge Clk);
    expect_out("hit5_dying", mk(2'd2, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0));
    pulse_hit();
    dying_to_respawn(2'd2, 3'b011);
    invuln_phase(2'd2, 3'b011, 1'b0);
    expect_out("extra_life_gain", mk(2'd3, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge Clk) extra_life = 1'b1;
    @(negedge Clk) extra_life = 1'b0;
    wait_drain("extra_gain");
    expect_out("hit6_dying", mk(2'd2, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0));
    pulse_hit();
    dying_to_respawn(2'd2, 3'b011);
    invuln_phase(2'd2, 3'b011, 1'b0);
    expect_out("extra_and_hit", mk(2'd2, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0));
    @(negedge Clk) begin extra_life = 1'b1; hit = 1'b1; end
    @(negedge Clk) begin extra_life = 1'b0; hit = 1'b0; end
    wait_drain("extra_hit");
`endif

    repeat (5) @(negedge Clk);
    wait_drain("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/life_ctrl.md
Name: life_ctrl

Overview:
- Lives/respawn sequencer for the player; drives the per-icon enables of the life-icon renderer and the game-over, freeze and blink controls for the player sprite.
- Runs on Clk. frame_clk is synchronised into the Clk domain and used only as a frame tick for counting.
- Collision logic feeds it hit events; the top level feeds it restart.

Parameters:
- NUM_LIVES, 3, starting and maximum lives; legal range 1..3.
- RESPAWN_FRAMES, 60, frame ticks spent frozen in DYING.
- INVULN_FRAMES, 120, frame ticks of hit immunity after respawn.
- BLINK_PERIOD, 8, frame ticks per player-visibility toggle during INVULN; power of 2.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  vertical-sync frame clock; asynchronous to Clk.
- hit  in  1  level; player collided with a hazard this cycle.
- restart  in  1  level; start a new game.
- lives  out  2  remaining lives, 0..NUM_LIVES.
- life_vis  out  3  bit i = 1 when lives > i; drives icon i.
- game_over  out  1  high while in GAMEOVER.
- player_freeze  out  1  high in DYING and GAMEOVER.
- player_visible  out  1  player sprite enable.
- respawn  out  1  one-Clk pulse; reload player position.

Behaviour:
- Reset values (async): state=ALIVE, lives=NUM_LIVES, life_vis=all bits below NUM_LIVES set, game_over=0, player_freeze=0, player_visible=1, respawn=0, frame counter=0, sync flops=0.
- Frame tick (ftick):
  - frame_clk passes through 2 synchroniser flops plus 1 history flop.
  - ftick is high for exactly one Clk cycle when the synchronised level goes 0->1, i.e. 3 Clk edges after frame_clk rises.
  - A frame_clk high pulse shorter than 2 Clk periods may be missed; this is allowed.
- States:
  - ALIVE: hit=1 -> lives<=lives-1, fcnt<=0, go to DYING.
  - DYING: fcnt increments on each ftick. On the ftick where fcnt==RESPAWN_FRAMES-1: go to GAMEOVER if lives==0, else go to RESPAWN.
  - RESPAWN: lasts exactly one Clk cycle with respawn=1; then go to INVULN with fcnt=0.
  - INVULN: hit is ignored. fcnt increments on each ftick. On the ftick where fcnt==INVULN_FRAMES-1, go to ALIVE.
  - GAMEOVER: hold until restart.
- restart:
  - Accepted in every state and has priority over hit and ftick.
  - Action: lives<=NUM_LIVES, fcnt<=0, go to RESPAWN.
- hit in DYING, RESPAWN, INVULN or GAMEOVER has no effect.
- hit held high across the INVULN->ALIVE transition: costs a life on the first ALIVE cycle. This is intended; the collision logic must deassert hit.
- lives never underflows; a decrement only occurs from ALIVE, where lives>=1.
- fcnt width: enough bits for max(RESPAWN_FRAMES, INVULN_FRAMES); it never wraps.
- player_visible:
  - 1 in ALIVE, DYING and RESPAWN.
  - 0 in GAMEOVER.
  - In INVULN: fcnt[log2(BLINK_PERIOD)] inverted, so the sprite is visible for the first BLINK_PERIOD ticks.
- All outputs are registered or decoded from registered state only; no combinational path from hit or restart to any output.

Optional Feature:
- LIFE_CTRL_EXTRA_LIFE_EN defined:
  - Adds input port extra_life (1 bit, pulse).
  - In ALIVE or INVULN, lives<=min(lives+1, NUM_LIVES).
  - extra_life and hit in the same ALIVE cycle: lives unchanged, go to DYING.
  - extra_life is ignored in other states.
- Macro not defined: the port is absent and lives only decrements or reloads.

Decomposition:
- Package life_pkg:
  - state enum life_state_t {ALIVE, DYING, RESPAWN, INVULN, GAMEOVER}.
  - LIVES_W=2.
  - MAX_ICONS=3.
- Sub-module frame_tick_sync: Clk, Reset, async_in -> tick. It holds the 2-flop synchroniser and the edge detector, and is reusable by other frame-rate blocks.

Test Plan:
All scenarios use RESPAWN_FRAMES=4, INVULN_FRAMES=8, BLINK_PERIOD=2.
- Reset deasserted -> lives=3, life_vis=3'b111, player_visible=1, game_over=0. Rising edge of frame_clk -> ftick exactly 3 Clk later, 1 cycle wide.
- One-cycle hit in ALIVE -> lives=2, life_vis=3'b011, player_freeze=1. After 4 ftick pulses, respawn high for 1 cycle, then INVULN.
- In INVULN, player_visible pattern over ticks 0..7 = 1,1,0,0,1,1,0,0. hit asserted during INVULN -> lives stays 2. After 8 ftick pulses -> ALIVE, player_visible=1.
- Three hits, each after a full respawn -> lives=0, life_vis=3'b000. After 4 ftick pulses -> game_over=1, player_visible=0, no respawn pulse.
- restart during GAMEOVER, and separately during DYING with hit high in the same cycle -> lives=3, respawn pulse next cycle, no decrement.
- With LIFE_CTRL_EXTRA_LIFE_EN: lives=2 plus extra_life -> 3. extra_life at lives=3 -> stays 3. extra_life and hit together at lives=2 -> lives=2, state DYING.
